// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state encoding and widths for the fetch sequencer
//
// Purpose: single home for the sequencer state codes so decode and the
// memory model agree on them.
// Contents:
//   STATE_W          width of the state register (2 bits)
//   state_t          START=00, FETCH=01, HOLD=10 (code 11 is unused)
//   INSTR_W          instruction byte width
//   is_hold()        helper: state presents an instruction to decode

package fetch_seq_pkg;

    localparam int STATE_W = 2;
    localparam int INSTR_W = 8;

    typedef enum logic [STATE_W-1:0] {
        STATE_START = 2'b00,
        STATE_FETCH = 2'b01,
        STATE_HOLD  = 2'b10
    } state_t;

    function automatic logic is_hold(input state_t s);
        return (s == STATE_HOLD);
    endfunction

endpackage

// File: rtl/fetch_seq_inc.sv
// rtl/fetch_seq_inc.sv - wrapping ripple half-adder incrementer
//
// Purpose: y = a + 1 modulo 2^WIDTH, no carry out.
// Ports:
//   a_i  in  WIDTH  operand
//   y_o  out WIDTH  operand plus one, wrapping

module inc
    import fetch_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    // carry[i] is the carry into bit i; the +1 enters as carry[0].
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y_o[i] = a_i[i] ^ carry[i];
        // The carry out of the top bit is dropped, which gives the wrap.
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = a_i[i] & carry[i];
        end
    end

endmodule

// File: rtl/fetch_seq_mux.sv
// rtl/fetch_seq_mux.sv - two-input word multiplexer
//
// Purpose: out = sel ? in1 : in0.
// Ports:
//   sel_i  in  1      select, high picks in1_i
//   in0_i  in  WIDTH  input chosen when sel_i is low
//   in1_i  in  WIDTH  input chosen when sel_i is high
//   out_o  out WIDTH  selected word

module mux
    import fetch_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer between instruction memory and decode
//
// Purpose: holds the PC, issues byte fetches, presents each fetched byte to
// decode with a valid/ready handshake and applies jump redirects on accept.
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   asynchronous active-high reset
//   mem_req      out 1   fetch request (high in FETCH)
//   mem_addr     out AW  fetch address, always the PC
//   mem_ack      in  1   mem_rdata valid this cycle
//   mem_rdata    in  8   fetched byte
//   instr        out 8   latched instruction
//   instr_valid  out 1   instr is valid (high in HOLD)
//   instr_ready  in  1   decode accepts instr this cycle
//   jump         in  1   accepted instruction redirects the PC
//   jump_target  in  AW  redirect address, used only on accept

module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int          AW        = 16,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic [AW-1:0]      jump_target
);

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic               req_c;
    logic               valid_c;
    logic               pc_load;
    logic               instr_load;
    logic               jump_sel;
    logic [AW-1:0]      pc_inc;
    logic [AW-1:0]      pc_new;

    // Next-state and control decode. The outputs req_c/valid_c depend on
    // state_q alone, so no input reaches an output combinationally.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        valid_c    = 1'b0;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        case (state_q)
            STATE_START: begin
                state_d = STATE_FETCH;
            end
            STATE_FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    instr_load = 1'b1;
                    pc_load    = 1'b1;
                    state_d    = STATE_HOLD;
                end
            end
            STATE_HOLD: begin
                valid_c = 1'b1;
                if (instr_ready) begin
                    state_d = STATE_FETCH;
                    // PC was already advanced at ack; only a jump reloads it.
                    pc_load = jump;
                end
            end
            default: begin
                // Unused code 11 behaves exactly like START.
                state_d = STATE_FETCH;
            end
        endcase
    end

    assign jump_sel = is_hold(state_q) & instr_ready & jump;

    inc #(.WIDTH(AW)) u_inc (
        .a_i (pc_q),
        .y_o (pc_inc)
    );

    mux #(.WIDTH(AW)) u_target_mux (
        .sel_i (jump_sel),
        .in0_i (pc_inc),
        .in1_i (jump_target),
        .out_o (pc_new)
    );

    mux #(.WIDTH(AW)) u_pc_mux (
        .sel_i (pc_load),
        .in0_i (pc_q),
        .in1_i (pc_new),
        .out_o (pc_d)
    );

    mux #(.WIDTH(INSTR_W)) u_instr_mux (
        .sel_i (instr_load),
        .in0_i (instr_q),
        .in1_i (mem_rdata),
        .out_o (instr_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_START;
            pc_q    <= RESET_VEC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign mem_req     = req_c;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_c;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - scoreboard bench for fetch_seq with randomized memory and decode

module tb_fetch_seq;

    localparam int          AW = 16;
    localparam logic [15:0] RV = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [15:0] jump_target;

    always #5 clk = ~clk;

    fetch_seq #(.AW(AW), .RESET_VEC(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_target (jump_target)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_instr_q[$];
    logic [15:0] model_addr;

    bit run_en = 0, mon_en = 0, after_rst = 0;
    bit drv_acked = 0, drv_accepted = 0;
    bit prev_req = 0, prev_valid = 0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  held_instr = '0;

    int ack_lat = 0, ack_cnt = 0, ack_pct = 100, ready_pct = 100, jump_pct = 0;
    int stall_left = 0;
    bit force_jump = 0;
    logic [15:0] force_target = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory and decode stimulus. The model follows the rules directly:
    // a fetch returns the byte for the modelled address; an accepted
    // instruction moves the next fetch to the target or to address+1.
    always @(negedge clk) begin : drv
        bit a;
        bit r;
        bit j;
        logic [15:0] t;
        if (run_en) begin
            if (mem_req) begin
                if (ack_lat < 0) a = ($urandom_range(99) < ack_pct);
                else             a = (ack_cnt >= ack_lat);
                if (a) ack_cnt = 0; else ack_cnt++;
                mem_ack   = a;
                mem_rdata = a ? mem_addr[7:0] : 8'($urandom);
                if (a) exp_instr_q.push_back(model_addr[7:0]);
            end else begin
                a = 1'b0;
                ack_cnt   = 0;
                mem_ack   = ($urandom_range(3) == 0);
                mem_rdata = 8'($urandom);
            end
            drv_acked = a;

            if (instr_valid && stall_left > 0) begin
                r = 1'b0;
                j = stall_left[0];
                stall_left--;
            end else begin
                r = ($urandom_range(99) < ready_pct);
                j = ($urandom_range(99) < jump_pct);
            end
            t = 16'($urandom);
            if (instr_valid && r && force_jump) begin
                j = 1'b1;
                t = force_target;
                force_jump = 1'b0;
            end
            instr_ready = r;
            jump        = j;
            jump_target = t;
            drv_accepted = instr_valid && r;
            if (drv_accepted) begin
                model_addr = j ? t : model_addr + 16'd1;
                exp_addr_q.push_back(model_addr);
            end
        end
    end

    // Monitor: handshake shape, fetch addresses and delivered instructions.
    always @(posedge clk) begin : mon
        bit er;
        bit ev;
        #1;
        if (mon_en) begin
            er = after_rst ? 1'b1 : (drv_accepted || (prev_req && !drv_acked));
            ev = after_rst ? 1'b0 : (drv_acked || (prev_valid && !drv_accepted));
            chk("mem_req", 32'(mem_req), 32'(er));
            chk("instr_valid", 32'(instr_valid), 32'(ev));
            if (mem_req && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fetch_addr: got %0h expected none queued", mem_addr);
                end else begin
                    chk("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end
            end else if (mem_req) begin
                chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            end
            if (instr_valid && !prev_valid) begin
                if (exp_instr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL instr: got %0h expected none queued", instr);
                end else begin
                    chk("instr", 32'(instr), 32'(exp_instr_q.pop_front()));
                end
                held_instr = instr;
            end else if (instr_valid) begin
                chk("instr_stable", 32'(instr), 32'(held_instr));
            end
            prev_req   = mem_req;
            prev_valid = instr_valid;
            prev_addr  = mem_addr;
            after_rst  = 1'b0;
        end
    end

    task automatic do_reset();
        run_en = 0;
        mon_en = 0;
        @(negedge clk);
        rst         = 1'b1;
        mem_ack     = 1'b1;
        mem_rdata   = 8'hAA;
        instr_ready = 1'b1;
        jump        = 1'b1;
        jump_target = 16'h1234;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'd0);
        chk("rst_async_valid", 32'(instr_valid), 32'd0);
        chk("rst_async_addr", 32'(mem_addr), 32'(RV));
        @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(RV));
        chk("rst_instr", 32'(instr), 32'd0);
        @(negedge clk);
        // Release with a stale ack still high; START must ignore it.
        rst = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_addr = RV;
        exp_addr_q.push_back(RV);
        prev_req     = 1'b0;
        prev_valid   = 1'b0;
        drv_acked    = 1'b0;
        drv_accepted = 1'b0;
        ack_cnt      = 0;
        after_rst    = 1'b1;
        mon_en       = 1;
        @(posedge clk);
        run_en = 1;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        instr_ready = 1'b0;
        jump = 1'b0;
        jump_target = '0;

        ack_lat = 0; ready_pct = 100; jump_pct = 0;
        do_reset();
        repeat (8) @(posedge clk);

        ack_lat = 3;
        repeat (16) @(posedge clk);

        ack_lat = 0; stall_left = 5;
        repeat (16) @(posedge clk);

        force_target = 16'h2000; force_jump = 1;
        repeat (8) @(posedge clk);

        force_target = 16'hFFFF; force_jump = 1;
        repeat (8) @(posedge clk);

        ack_lat = -1; ack_pct = 50; ready_pct = 60; jump_pct = 25;
        repeat (400) @(posedge clk);

        // Park in FETCH with no ack, then reset mid-request.
        ack_lat = 100000; ready_pct = 100; jump_pct = 0;
        w = 0;
        @(posedge clk); #1;
        while (!mem_req && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!mem_req) begin
            checks++; errors++;
            $display("FAIL wait_fetch: got mem_req=0 expected 1 within 50 cycles");
        end
        do_reset();
        ack_lat = 2;
        repeat (14) @(posedge clk);

        run_en = 0;
        mon_en = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
